// File: rtl/aoc_pkg.sv
// Shared definitions for the dial-solver front end: ASCII byte classes,
// the command parser state encoding and the default command-count width.
package aoc_pkg;

   localparam int unsigned DEF_COUNT_WIDTH = 10;

   localparam logic [7:0] CH_L  = 8'h4C;
   localparam logic [7:0] CH_R  = 8'h52;
   localparam logic [7:0] CH_LF = 8'h0A;
   localparam logic [7:0] CH_CR = 8'h0D;
   localparam logic [7:0] CH_0  = 8'h30;
   localparam logic [7:0] CH_9  = 8'h39;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DIGITS = 2'd1,
      ST_EMIT   = 2'd2,
      ST_SKIP   = 2'd3
   } feed_state_e;

   function automatic logic is_digit(input logic [7:0] b);
      return (b >= CH_0) && (b <= CH_9);
   endfunction

   function automatic logic is_letter(input logic [7:0] b);
      return (b == CH_L) || (b == CH_R);
   endfunction

   // Only meaningful when is_digit(b) holds.
   function automatic logic [3:0] digit_val(input logic [7:0] b);
      return 4'(b - CH_0);
   endfunction

endpackage

// File: rtl/rotation_pacer.sv
// Shadow of the solver's internal step counter: loaded with the count on each
// command strobe, then counts down to zero one step per cycle.
module rotation_pacer
   import aoc_pkg::*;
#(
   parameter int unsigned COUNT_WIDTH = DEF_COUNT_WIDTH
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   load_i,
   input  logic [COUNT_WIDTH-1:0] count_i,
   output logic                   pace_zero_o,
   output logic                   next_zero_c_o
);

   logic [COUNT_WIDTH-1:0] pace_q;
   logic [COUNT_WIDTH-1:0] pace_d;
   logic                   pace_zero_q;

   always_comb begin
      pace_d = pace_q;
      if (load_i) begin
         pace_d = count_i;
      end else if (pace_q != '0) begin
         pace_d = pace_q - COUNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pace_q      <= '0;
         pace_zero_q <= 1'b1;
      end else begin
         pace_q      <= pace_d;
         pace_zero_q <= (pace_d == '0);
      end
   end

   assign pace_zero_o   = pace_zero_q;
   // Lets the parser schedule a strobe for the first cycle the solver is free.
   assign next_zero_c_o = (pace_d == '0);

endmodule

// File: rtl/rotation_feeder.sv
// Parses an ASCII rotation stream ("L68\n", "R30\r\n", ...) into paced
// direction/count commands for the dial solver.
module rotation_feeder
   import aoc_pkg::*;
#(
   parameter int unsigned COUNT_WIDTH = DEF_COUNT_WIDTH
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   input  logic [7:0]             in_data,
   output logic                   in_ready,
   output logic                   valid,
   output logic                   step_direction,
   output logic [COUNT_WIDTH-1:0] step_count,
   output logic                   idle,
   output logic                   err
);

   localparam int unsigned ACC_W = COUNT_WIDTH + 4;

   feed_state_e            state_q;
   logic                   valid_q;
   logic                   dir_q;
   logic [COUNT_WIDTH-1:0] count_q;
   logic                   err_q;
   logic                   line_dir_q;
   logic                   seen_q;
   logic [COUNT_WIDTH-1:0] acc_q;

   logic                   accept;
   logic                   is_cr;
   logic [ACC_W-1:0]       acc_ext;
   logic                   acc_ovf;
   logic                   pace_zero;
   logic                   next_zero;

   assign in_ready = ~rst & (state_q != ST_EMIT);
   assign accept   = in_valid & in_ready;
   assign is_cr    = (in_data == CH_CR);

   // Extra headroom bits catch counts that no longer fit the solver port.
   assign acc_ext  = ACC_W'(acc_q) * ACC_W'(10) + ACC_W'(digit_val(in_data));
   assign acc_ovf  = |acc_ext[ACC_W-1:COUNT_WIDTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         valid_q    <= 1'b0;
         dir_q      <= 1'b0;
         count_q    <= '0;
         err_q      <= 1'b0;
         line_dir_q <= 1'b0;
         seen_q     <= 1'b0;
         acc_q      <= '0;
      end else begin
         valid_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (accept && !is_cr) begin
                  if (is_letter(in_data)) begin
                     line_dir_q <= (in_data == CH_R);
                     acc_q      <= '0;
                     seen_q     <= 1'b0;
                     state_q    <= ST_DIGITS;
                  end else if (in_data != CH_LF) begin
                     err_q   <= 1'b1;
                     state_q <= ST_SKIP;
                  end
               end
            end
            ST_DIGITS: begin
               if (accept && !is_cr) begin
                  if (is_digit(in_data)) begin
                     if (acc_ovf) begin
                        err_q   <= 1'b1;
                        state_q <= ST_SKIP;
                     end else begin
                        acc_q  <= acc_ext[COUNT_WIDTH-1:0];
                        seen_q <= 1'b1;
                     end
                  end else if (in_data == CH_LF) begin
                     if (!seen_q) begin
                        err_q   <= 1'b1;
                        state_q <= ST_IDLE;
                     end else if (next_zero) begin
                        // Solver is already free: strobe without an EMIT stall.
                        valid_q <= 1'b1;
                        dir_q   <= line_dir_q;
                        count_q <= acc_q;
                        state_q <= ST_IDLE;
                     end else begin
                        state_q <= ST_EMIT;
                     end
                  end else begin
                     err_q   <= 1'b1;
                     state_q <= ST_SKIP;
                  end
               end
            end
            ST_EMIT: begin
               if (next_zero) begin
                  valid_q <= 1'b1;
                  dir_q   <= line_dir_q;
                  count_q <= acc_q;
                  state_q <= ST_IDLE;
               end
            end
            ST_SKIP: begin
               if (accept && (in_data == CH_LF)) begin
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   rotation_pacer #(
      .COUNT_WIDTH (COUNT_WIDTH)
   ) u_pacer (
      .clk           (clk),
      .rst           (rst),
      .load_i        (valid_q),
      .count_i       (count_q),
      .pace_zero_o   (pace_zero),
      .next_zero_c_o (next_zero)
   );

   assign valid          = valid_q;
   assign step_direction = dir_q;
   assign step_count     = count_q;
   assign err            = err_q;
   assign idle           = ~rst & (state_q == ST_IDLE) & pace_zero & ~valid_q;

endmodule

// File: tb/tb_rotation_feeder.sv
// Self-checking bench for rotation_feeder: directed lines from the test plan
// plus random line streams, checked cycle by cycle against a line-level model.
module tb_rotation_feeder;
   import aoc_pkg::*;

   localparam int unsigned CW   = 10;
   localparam int          MAXC = (1 << CW) - 1;

   logic          clk      = 1'b0;
   logic          rst      = 1'b1;
   logic          in_valid = 1'b0;
   logic [7:0]    in_data  = 8'h00;
   logic          in_ready;
   logic          valid;
   logic          step_direction;
   logic [CW-1:0] step_count;
   logic          idle;
   logic          err;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   // Model: pending command, last emitted command, held outputs, current line prefix.
   bit pend = 0;      int pend_v = 0;  bit pend_dir = 0;  int pend_n = 0;
   bit have_last = 0; int last_v = 0;  int last_n = 0;
   bit hold_dir = 0;  int hold_cnt = 0; bit err_e = 0;
   int ln_len = 0;    bit ln_bad = 0;  bit ln_dir = 0;    int ln_val = 0;
   int gap_pct = 0;
   int n_valid = 0;
   int dial = 50;
   int zc = 0;

   always #5 clk = ~clk;

   rotation_feeder #(.COUNT_WIDTH(CW)) dut (
      .clk            (clk),
      .rst            (rst),
      .in_valid       (in_valid),
      .in_data        (in_data),
      .in_ready       (in_ready),
      .valid          (valid),
      .step_direction (step_direction),
      .step_count     (step_count),
      .idle           (idle),
      .err            (err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s @cycle %0d: observed %0d expected %0d", tag, cyc, obs, exp);
      end
   endtask

   function automatic bit quiet_e();
      return (ln_len == 0) && !pend && (!have_last || (cyc >= last_v + last_n + 1));
   endfunction

   // Apply one accepted byte to the line-level model; effects show next cycle.
   task automatic model_byte(input logic [7:0] d);
      int nv;
      int ev;
      if (d == CH_CR) return;
      if (d == CH_LF) begin
         if (!ln_bad && ln_len == 1) begin
            err_e = 1'b1;
         end else if (!ln_bad && ln_len > 1) begin
            ev = cyc + 1;
            if (have_last && (last_v + last_n + 1 > ev)) ev = last_v + last_n + 1;
            pend = 1'b1; pend_v = ev; pend_dir = ln_dir; pend_n = ln_val;
         end
         ln_len = 0; ln_bad = 1'b0;
         return;
      end
      if (!ln_bad) begin
         if (ln_len == 0) begin
            if (d == CH_L || d == CH_R) begin
               ln_dir = (d == CH_R); ln_val = 0;
            end else begin
               ln_bad = 1'b1;
            end
         end else if (d >= CH_0 && d <= CH_9) begin
            nv = ln_val * 10 + int'(d - CH_0);
            if (nv > MAXC) ln_bad = 1'b1;
            else ln_val = nv;
         end else begin
            ln_bad = 1'b1;
         end
         if (ln_bad) err_e = 1'b1;
      end
      ln_len++;
   endtask

   task automatic cycle(input bit v, input logic [7:0] d, output bit acc);
      bit ve;
      bit rdy_e;
      bit idle_e;
      in_valid = v;
      in_data  = d;
      @(negedge clk);
      ve     = pend && (pend_v == cyc);
      rdy_e  = !pend || (cyc >= pend_v);
      idle_e = quiet_e();
      if (ve) begin hold_dir = pend_dir; hold_cnt = pend_n; end
      chk("valid",    32'(valid),          32'(ve));
      chk("dir",      32'(step_direction), 32'(hold_dir));
      chk("count",    32'(step_count),     32'(hold_cnt));
      chk("in_ready", 32'(in_ready),       32'(rdy_e));
      chk("idle",     32'(idle),           32'(idle_e));
      chk("err",      32'(err),            32'(err_e));
      if (valid === 1'b1) begin
         n_valid++;
         if (step_direction) dial = (dial + int'(step_count)) % 100;
         else dial = ((dial - int'(step_count)) % 100 + 100) % 100;
         if (dial == 0) zc++;
      end
      acc = v && rdy_e;
      if (ve) begin last_v = cyc; last_n = pend_n; have_last = 1'b1; pend = 1'b0; end
      if (acc) model_byte(d);
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic do_reset(input int n);
      in_valid = 1'b0;
      rst = 1'b1;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         chk("rst_in_ready", 32'(in_ready), 32'd0);
         chk("rst_idle",     32'(idle),     32'd0);
         if (i > 0) begin
            chk("rst_valid", 32'(valid),          32'd0);
            chk("rst_dir",   32'(step_direction), 32'd0);
            chk("rst_count", 32'(step_count),     32'd0);
            chk("rst_err",   32'(err),            32'd0);
         end
         @(posedge clk);
         #1;
         cyc++;
      end
      rst = 1'b0;
      pend = 1'b0; have_last = 1'b0; hold_dir = 1'b0; hold_cnt = 0;
      err_e = 1'b0; ln_len = 0; ln_bad = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      bit acc;
      int tries;
      acc = 1'b0;
      tries = 0;
      while (!acc && tries < 3000) begin
         if (gap_pct != 0 && $urandom_range(0, 99) < gap_pct) cycle(1'b0, 8'($urandom), acc);
         else cycle(1'b1, b, acc);
         tries++;
      end
      chk("byte_accept", 32'(acc), 32'd1);
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send_byte(s[i]);
   endtask

   task automatic drain();
      bit a;
      int k;
      k = 0;
      while (!quiet_e() && k < 3000) begin
         cycle(1'b0, 8'h00, a);
         k++;
      end
      cycle(1'b0, 8'h00, a);
      cycle(1'b0, 8'h00, a);
   endtask

   task automatic send_random_line();
      logic [7:0] q[$];
      logic [7:0] ds[$];
      int r;
      int n;
      int len;
      int b;
      r = $urandom_range(0, 99);
      if (r < 8) begin
         if ($urandom_range(0, 1) == 1) q.push_back(CH_CR);
      end else if (r < 18) begin
         len = $urandom_range(1, 5);
         for (int i = 0; i < len; i++) begin
            b = $urandom_range(0, 255);
            if (b == 10) b = 11;
            q.push_back(8'(b));
         end
      end else if (r < 21) begin
         q.push_back(($urandom_range(0, 1) == 1) ? CH_R : CH_L);
      end else begin
         n = (r < 28) ? $urandom_range(0, 1200) : $urandom_range(0, 40);
         do begin
            ds.push_front(CH_0 + 8'(n % 10));
            n = n / 10;
         end while (n > 0);
         if (r < 23) q.push_back(ds[0]);
         q.push_back(($urandom_range(0, 1) == 1) ? CH_R : CH_L);
         foreach (ds[i]) q.push_back(ds[i]);
         if ($urandom_range(0, 9) < 3) q.push_back(CH_CR);
      end
      q.push_back(CH_LF);
      foreach (q[i]) send_byte(q[i]);
   endtask

   initial begin
      int base;
      @(posedge clk);
      #1;
      do_reset(3);

      base = n_valid;
      send_str("L68\n");
      drain();
      chk("l68_cmds", 32'(n_valid - base), 32'd1);

      base = n_valid;
      send_str("R30\nL5\n");
      drain();
      chk("r30_l5_cmds", 32'(n_valid - base), 32'd2);

      base = n_valid;
      send_str("L0\nR1\n");
      drain();
      chk("zero_count_cmds", 32'(n_valid - base), 32'd2);

      base = n_valid;
      send_str("X12\nR7\r\n");
      drain();
      chk("bad_line_cmds", 32'(n_valid - base), 32'd1);
      chk("bad_line_err",  32'(err), 32'd1);

      do_reset(2);
      base = n_valid;
      send_str("R1024\nL3\n");
      drain();
      chk("overflow_cmds", 32'(n_valid - base), 32'd1);
      chk("overflow_err",  32'(err), 32'd1);

      do_reset(2);
      send_str("R45");
      do_reset(2);
      base = n_valid;
      send_str("L2\n");
      drain();
      chk("midreset_cmds", 32'(n_valid - base), 32'd1);

      do_reset(2);
      dial = 50;
      zc = 0;
      send_str("L68\nL30\nR48\nL5\nR60\nL55\nL1\nL99\nR14\nL82\n");
      drain();
      chk("example_zero_count", 32'(zc), 32'd3);

      do_reset(2);
      gap_pct = 25;
      for (int i = 0; i < 80; i++) send_random_line();
      drain();
      gap_pct = 0;
      send_str("\r\nR9\n");
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
